// File: rtl/rand_arbiter_if.sv
// Handshake bundle between game-logic requesters (master) and rand_arbiter (slave).
interface rand_arbiter_if #(
   parameter int N = 3
);
   logic [7:0]     rand_in;
   logic [N-1:0]   req_i;
   logic [8*N-1:0] limit_i;
   logic [N-1:0]   ack_o;
   logic [7:0]     val_o;
   logic           busy_o;

   modport master (output rand_in, req_i, limit_i, input ack_o, val_o, busy_o);
   modport slave  (input rand_in, req_i, limit_i, output ack_o, val_o, busy_o);
endinterface

// File: rtl/rand_arbiter.sv
// Round-robin share of the LFSR stream; each grant gets a value in [0, limit-1] by masked rejection.
// Optional RAND_ARB_FALLBACK_EN bounds latency by folding m - limit after MAX_TRIES rejects.
module rand_arbiter #(
   parameter int N         = 3,
   parameter int MAX_TRIES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   rand_arbiter_if.slave bus
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [3:0] TRY_LIM = 4'(MAX_TRIES);

   typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

   state_t         state;
   logic [IW-1:0]  last, winner, pick;
   logic [IW:0]    sum;
   logic           found;
   logic [7:0]     lim, mask, lim_k, mask_k, v1, v2, v3, m;
   logic           accept;
   logic [3:0]     tries;
   logic [N-1:0]   ack;
   logic [7:0]     val;
   logic           busy;

   assign bus.ack_o  = ack;
   assign bus.val_o  = val;
   assign bus.busy_o = busy;

   // Search starts just past the last winner, so the previous winner ends up lowest priority.
   always_comb begin
      pick  = last;
      found = 1'b0;
      sum   = '0;
      for (int i = N; i >= 1; i--) begin
         sum = {1'b0, last} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
         if (bus.req_i[sum[IW-1:0]]) begin
            pick  = sum[IW-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      lim_k = '0;
      for (int k = 0; k < N; k++)
         if (pick == IW'(k)) lim_k = bus.limit_i[8*k +: 8];
   end

   // Smearing limit-1 right gives 2^ceil(log2(limit))-1; limit 0 wraps to 0xFF, limit 1 to 0x00.
   always_comb begin
      v1     = lim_k - 8'd1;
      v2     = v1 | (v1 >> 1);
      v3     = v2 | (v2 >> 2);
      mask_k = v3 | (v3 >> 4);
   end

   assign m      = bus.rand_in & mask;
   assign accept = (lim == 8'd0) || (m < lim);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         ack    <= '0;
         val    <= '0;
         busy   <= 1'b0;
         last   <= IW'(N-1);
         winner <= '0;
         lim    <= '0;
         mask   <= '0;
         tries  <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE: begin
               if (found) begin
                  winner <= pick;
                  lim    <= lim_k;
                  mask   <= mask_k;
                  tries  <= '0;
                  busy   <= 1'b1;
                  state  <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (accept) begin
                  val   <= m;
                  ack   <= {{(N-1){1'b0}}, 1'b1} << winner;
                  state <= DONE;
               end
`ifdef RAND_ARB_FALLBACK_EN
               // m < 2*limit because mask < 2*limit, so the fold stays in range.
               else if (tries == TRY_LIM) begin
                  val   <= m - lim;
                  ack   <= {{(N-1){1'b0}}, 1'b1} << winner;
                  state <= DONE;
               end
`endif
               else if (tries != TRY_LIM) begin
                  tries <= tries + 4'd1;
               end
            end
            DONE: begin
               last  <= winner;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
